// File: rtl/shift_pkg.sv
// shift_pkg: op and FSM state encodings shared by the shift unit.
package shift_pkg;
  localparam logic [2:0] OP_SLL = 3'd0;
  localparam logic [2:0] OP_SRL = 3'd1;
  localparam logic [2:0] OP_SRA = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;
endpackage

// File: rtl/shift_stage.sv
// shift_stage: one logarithmic shift/rotate stage by 2^k_i, with the bit shifted out.
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [2:0]       op_i,
  input  logic [SHW-1:0]   k_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] data_o,
  output logic             carry_o,
  output logic             cv_o
);
  logic [SHW-1:0]   s;
  logic [SHW-1:0]   ns;
  logic [WIDTH-1:0] sll;
  logic [WIDTH-1:0] srl;
  logic [WIDTH-1:0] sra;
  logic [WIDTH-1:0] rol;
  logic [WIDTH-1:0] ror;
  // ns wraps to WIDTH-s; s never exceeds WIDTH/2 so ns is never zero
  always_comb begin
    s       = SHW'(1) << k_i;
    ns      = -s;
    sll     = data_i << s;
    srl     = data_i >> s;
    sra     = $signed(data_i) >>> s;
    rol     = sll | (data_i >> ns);
    ror     = srl | (data_i << ns);
    cv_o    = en_i && (op_i <= OP_ROR);
    data_o  = !cv_o ? data_i :
              op_i == OP_SLL ? sll :
              op_i == OP_SRL ? srl :
              op_i == OP_SRA ? sra :
              op_i == OP_ROL ? rol : ror;
    carry_o = op_i == OP_SLL ? data_i[ns] :
              op_i == OP_ROL ? rol[0] :
              op_i == OP_ROR ? ror[WIDTH-1] : data_i[s - SHW'(1)];
  end
endmodule

// File: rtl/shift_unit_seq.sv
// shift_unit_seq: multi-cycle shift/rotate unit resolving one log2 stage per clock.
module shift_unit_seq
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             err
);
  state_e           state_q, state_d;
  logic [SHW-1:0]   k_q;
  logic [SHW-1:0]   shamt_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] result_q;
  logic             cy_q, carry_q, zero_q, err_q;
  logic             accept, last;
  logic [WIDTH-1:0] st_data;
  logic             st_c, st_cv;

  shift_stage #(.WIDTH(WIDTH), .SHW(SHW)) u_stage (
    .data_i (work_q),
    .op_i   (op_q),
    .k_i    (k_q),
    .en_i   (shamt_q[k_q]),
    .data_o (st_data),
    .carry_o(st_c),
    .cv_o   (st_cv)
  );

  always_comb begin
    accept  = start && (state_q != S_SHIFT);
    last    = k_q == SHW'(SHW - 1);
    state_d = accept ? S_SHIFT :
              state_q == S_SHIFT ? (last ? S_DONE : S_SHIFT) : S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      shamt_q  <= '0;
      op_q     <= OP_SLL;
      work_q   <= '0;
      cy_q     <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        work_q  <= a;
        op_q    <= op;
        shamt_q <= shamt;
        k_q     <= '0;
        cy_q    <= 1'b0;
      end else if (state_q == S_SHIFT) begin
        work_q <= st_data;
        k_q    <= k_q + SHW'(1);
        if (st_cv) cy_q <= st_c;
        if (last) begin
          result_q <= st_data;
          carry_q  <= st_cv ? st_c : cy_q;
          zero_q   <= st_data == '0;
          err_q    <= op_q > OP_ROR;
        end
      end
    end
  end

  assign busy   = state_q == S_SHIFT;
  assign done   = state_q == S_DONE;
  assign result = result_q;
  assign carry  = carry_q;
  assign zero   = zero_q;
  assign err    = err_q;
endmodule

// File: tb/tb_shift_unit_seq.sv
// tb_shift_unit_seq: directed checks of shift_unit_seq at WIDTH=16 and WIDTH=32.
module tb_shift_unit_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        s16, busy16, done16, c16, z16, e16;
  logic [2:0]  op16;
  logic [15:0] a16, r16;
  logic [3:0]  sh16;
  logic        s32, busy32, done32, c32, z32, e32;
  logic [2:0]  op32;
  logic [31:0] a32, r32;
  logic [4:0]  sh32;
  int passed = 0;
  int total  = 0;

  shift_unit_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(s16), .op(op16), .a(a16), .shamt(sh16),
    .busy(busy16), .done(done16), .result(r16), .carry(c16), .zero(z16), .err(e16)
  );
  shift_unit_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(s32), .op(op32), .a(a32), .shamt(sh32),
    .busy(busy32), .done(done32), .result(r32), .carry(c32), .zero(z32), .err(e32)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic go16(input string tag, input logic [2:0] o, input logic [15:0] av,
                      input logic [3:0] sh, input logic [15:0] er, input logic ec,
                      input logic ez, input logic ee);
    op16 = o; a16 = av; sh16 = sh; s16 = 1'b1;
    tick;
    s16 = 1'b0; a16 = ~av; op16 = 3'd6; sh16 = ~sh;
    for (int i = 1; i <= 4; i++) begin
      chk({tag, "_busy"}, {31'd0, busy16}, 32'd1);
      chk({tag, "_nodone"}, {31'd0, done16}, 32'd0);
      tick;
    end
    chk({tag, "_done"}, {31'd0, done16}, 32'd1);
    chk({tag, "_idle"}, {31'd0, busy16}, 32'd0);
    chk({tag, "_res"}, {16'd0, r16}, {16'd0, er});
    chk({tag, "_carry"}, {31'd0, c16}, {31'd0, ec});
    chk({tag, "_zero"}, {31'd0, z16}, {31'd0, ez});
    chk({tag, "_err"}, {31'd0, e16}, {31'd0, ee});
    tick;
    chk({tag, "_pulse"}, {31'd0, done16}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; s16 = 1'b0; op16 = 3'd0; a16 = '0; sh16 = '0;
    s32 = 1'b0; op32 = 3'd0; a32 = '0; sh32 = '0;
    tick; tick;
    rst = 1'b0;
    chk("rst_busy", {31'd0, busy16}, 32'd0);
    chk("rst_done", {31'd0, done16}, 32'd0);
    chk("rst_res", {16'd0, r16}, 32'd0);
    chk("rst_zero", {31'd0, z16}, 32'd1);
    chk("rst_carry", {31'd0, c16}, 32'd0);
    chk("rst_err", {31'd0, e16}, 32'd0);
    chk("rst32_res", r32, 32'd0);
    tick;
    go16("sll4",    3'd0, 16'h0005, 4'd4,  16'h0050, 1'b0, 1'b0, 1'b0);
    go16("sll15",   3'd0, 16'hFFFF, 4'd15, 16'h8000, 1'b1, 1'b0, 1'b0);
    go16("sra1",    3'd2, 16'h8001, 4'd1,  16'hC000, 1'b1, 1'b0, 1'b0);
    go16("srl15",   3'd1, 16'h8000, 4'd15, 16'h0001, 1'b0, 1'b0, 1'b0);
    go16("rol1",    3'd3, 16'h8001, 4'd1,  16'h0003, 1'b1, 1'b0, 1'b0);
    go16("ror1",    3'd4, 16'h0001, 4'd1,  16'h8000, 1'b1, 1'b0, 1'b0);
    go16("srl1z",   3'd1, 16'h0001, 4'd1,  16'h0000, 1'b1, 1'b1, 1'b0);
    go16("sra15",   3'd2, 16'h8000, 4'd15, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    go16("resv",    3'd7, 16'h1234, 4'd5,  16'h1234, 1'b0, 1'b0, 1'b1);
    go16("sll0",    3'd0, 16'h0001, 4'd0,  16'h0001, 1'b0, 1'b0, 1'b0);
    // start pulses while busy must be ignored
    op16 = 3'd0; a16 = 16'h0003; sh16 = 4'd2; s16 = 1'b1;
    tick;
    s16 = 1'b0;
    chk("ign_busy1", {31'd0, busy16}, 32'd1);
    tick;
    op16 = 3'd1; a16 = 16'hFFFF; sh16 = 4'd7; s16 = 1'b1;
    tick;
    chk("ign_busy3", {31'd0, busy16}, 32'd1);
    tick;
    s16 = 1'b0;
    chk("ign_nodone4", {31'd0, done16}, 32'd0);
    tick;
    chk("ign_done5", {31'd0, done16}, 32'd1);
    chk("ign_res", {16'd0, r16}, 32'h000C);
    op16 = 3'd3; a16 = 16'h00F0; sh16 = 4'd4; s16 = 1'b1;
    tick;
    s16 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk("b2b_busy", {31'd0, busy16}, 32'd1);
      chk("b2b_nodone", {31'd0, done16}, 32'd0);
      chk("b2b_hold", {16'd0, r16}, 32'h000C);
      tick;
    end
    chk("b2b_done", {31'd0, done16}, 32'd1);
    chk("b2b_res", {16'd0, r16}, 32'h0F00);
    tick;
    // reset in cycle 2 aborts the op
    op16 = 3'd1; a16 = 16'hF000; sh16 = 4'd4; s16 = 1'b1;
    tick;
    s16 = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy16}, 32'd0);
    chk("abort_done", {31'd0, done16}, 32'd0);
    chk("abort_res", {16'd0, r16}, 32'd0);
    chk("abort_carry", {31'd0, c16}, 32'd0);
    chk("abort_zero", {31'd0, z16}, 32'd1);
    chk("abort_err", {31'd0, e16}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick;
      chk("abort_nodone", {31'd0, done16}, 32'd0);
    end
    go16("after_rst", 3'd1, 16'hF000, 4'd4, 16'h0F00, 1'b0, 1'b0, 1'b0);
    // WIDTH=32: done in cycle 6
    op32 = 3'd2; a32 = 32'h8000_0000; sh32 = 5'd31; s32 = 1'b1;
    tick;
    s32 = 1'b0; a32 = '0;
    for (int i = 1; i <= 5; i++) begin
      chk("w32_busy", {31'd0, busy32}, 32'd1);
      chk("w32_nodone", {31'd0, done32}, 32'd0);
      tick;
    end
    chk("w32_done", {31'd0, done32}, 32'd1);
    chk("w32_res", r32, 32'hFFFF_FFFF);
    chk("w32_carry", {31'd0, c32}, 32'd0);
    tick;
    op32 = 3'd4; a32 = 32'h0000_0001; sh32 = 5'd1; s32 = 1'b1;
    tick;
    s32 = 1'b0;
    repeat (5) tick;
    chk("w32r_done", {31'd0, done32}, 32'd1);
    chk("w32r_res", r32, 32'h8000_0000);
    chk("w32r_carry", {31'd0, c32}, 32'd1);
    chk("w32r_zero", {31'd0, z32}, 32'd0);
    chk("w32r_err", {31'd0, e32}, 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
